// File: rtl/trit_pkg.sv
// Shared types for the trinary resolver driver: trit encoding, driver FSM
// states and a small helper used when scanning a word.
package trit_pkg;

  // Two-bit trit code. 2'b10 is the neutral '+/-' value that must be
  // settled by the external resolver before it can be used.
  typedef enum logic [1:0] {
    TRIT_ZERO = 2'b00,
    TRIT_POS  = 2'b01,
    TRIT_AMB  = 2'b10,
    TRIT_NEG  = 2'b11
  } trit_t;

  // Driver sequencing states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    LOAD   = 3'd2,
    SETTLE = 3'd3,
    SAMPLE = 3'd4,
    DONE   = 3'd5
  } drv_state_t;

  // True when the trit still needs the resolver.
  function automatic logic is_ambiguous(input trit_t t);
    return (t == TRIT_AMB);
  endfunction

endpackage

// File: rtl/trit_resolve_driver_if.sv
// Request/response bundle between the trit datapath and the resolver driver.
//
// Handshake rules (both channels): a transfer happens on a rising clock edge
// where valid and ready are both high. The source holds valid and its payload
// stable from the cycle valid rises until that transfer; valid never waits on
// ready. The sink may raise or drop ready freely.
//   - request : source = datapath (req_valid/req_word), sink = driver (req_ready)
//   - response: source = driver (rsp_valid/rsp_word/rsp_err), sink = datapath (rsp_ready)
interface trit_resolve_driver_if #(
  parameter int N_TRITS = 8
);

  logic                   req_valid;
  logic                   req_ready;
  logic [2*N_TRITS-1:0]   req_word;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [2*N_TRITS-1:0]   rsp_word;
  logic                   rsp_err;

  // Datapath side: issues words, consumes resolved words.
  modport master (
    output req_valid,
    output req_word,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_word,
    input  rsp_err
  );

  // Driver side: accepts words, produces resolved words.
  modport slave (
    input  req_valid,
    input  req_word,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_word,
    output rsp_err
  );

endinterface

// File: rtl/trit_settle_timer.sv
// Loadable down-counter shared by the settle phase and the re-sample phase
// of the resolver driver. Load wins over counting; the count parks at zero.
module trit_settle_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Count register: reload on demand, otherwise step down while started.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (start && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/trit_resolve_driver.sv
// Initiator for the neutral-trinary resolver. Takes a packed word of trits,
// walks it LSB trit first, sends every ambiguous trit through the external
// resolver and returns the reassembled word with a sticky error flag for any
// trit that never settled.
//
// Timing per trit: an unambiguous trit costs its single SCAN cycle. An
// ambiguous trit costs SCAN + LOAD + (SETTLE_CYCLES-1) SETTLE cycles + one
// SAMPLE cycle, i.e. SETTLE_CYCLES+2, plus one cycle per extra re-sample.
// The LOAD cycle is the first cycle the resolver runs, so the first sample
// lands on the SETTLE_CYCLES-th resolver cycle after the load.
module trit_resolve_driver
  import trit_pkg::*;
#(
  parameter int N_TRITS       = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_WAIT      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  trit_resolve_driver_if.slave  bus,
  output logic                  res_rst,
  output logic [1:0]            res_initial_state,
  input  logic [1:0]            res_resolved_state,
  output drv_state_t            state
);

  localparam int W           = 2 * N_TRITS;
  localparam int IDX_W       = (N_TRITS > 1) ? $clog2(N_TRITS) : 1;
  localparam int TMR_MAX     = (SETTLE_CYCLES > MAX_WAIT) ? SETTLE_CYCLES : MAX_WAIT;
  localparam int TMR_W       = (TMR_MAX > 0) ? $clog2(TMR_MAX + 1) : 1;
  // Timer preload for the SETTLE run: SETTLE_CYCLES-1 cycles in SETTLE,
  // the timer expires on the last of them.
  localparam int SETTLE_LOAD = (SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0;

  drv_state_t        fsm_state;
  drv_state_t        next_state;
  logic [W-1:0]      word_q;
  logic [W-1:0]      word_n;
  logic [W-1:0]      acc;
  logic [W-1:0]      acc_n;
  logic              err;
  logic              err_n;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_n;

  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              res_rst_q;
  logic [1:0]        res_init_q;

  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_value;
  logic              tmr_start;
  logic              tmr_expired;

  trit_t             cur_trit;
  trit_t             sampled;
  logic              last_trit;

  assign cur_trit  = trit_t'(word_q[{idx, 1'b0} +: 2]);
  assign sampled   = trit_t'(res_resolved_state);
  assign last_trit = (idx == IDX_W'(N_TRITS - 1));

  trit_settle_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tmr_load),
    .load_value (tmr_value),
    .start      (tmr_start),
    .expired    (tmr_expired)
  );

  // Next-state and datapath updates for the trit walk.
  always_comb begin
    next_state = fsm_state;
    word_n     = word_q;
    acc_n      = acc;
    err_n      = err;
    idx_n      = idx;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    tmr_start  = 1'b0;

    case (fsm_state)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          word_n     = bus.req_word;
          acc_n      = '0;
          err_n      = 1'b0;
          idx_n      = '0;
          next_state = SCAN;
        end
      end

      SCAN: begin
        if (is_ambiguous(cur_trit)) begin
          next_state = LOAD;
        end else begin
          acc_n[{idx, 1'b0} +: 2] = cur_trit;
          if (last_trit) begin
            next_state = DONE;
          end else begin
            idx_n      = idx + 1'b1;
            next_state = SCAN;
          end
        end
      end

      LOAD: begin
        tmr_load = 1'b1;
        if (SETTLE_CYCLES > 1) begin
          tmr_value  = TMR_W'(SETTLE_LOAD);
          next_state = SETTLE;
        end else begin
          tmr_value  = TMR_W'(MAX_WAIT);
          next_state = SAMPLE;
        end
      end

      SETTLE: begin
        if (tmr_expired) begin
          tmr_load   = 1'b1;
          tmr_value  = TMR_W'(MAX_WAIT);
          next_state = SAMPLE;
        end else begin
          tmr_start = 1'b1;
        end
      end

      SAMPLE: begin
        if (!is_ambiguous(sampled) || tmr_expired) begin
          // Either a settled value or the wait budget is spent; an unsettled
          // trit is returned as-is and flagged.
          acc_n[{idx, 1'b0} +: 2] = sampled;
          if (is_ambiguous(sampled)) begin
            err_n = 1'b1;
          end
          if (last_trit) begin
            next_state = DONE;
          end else begin
            idx_n      = idx + 1'b1;
            next_state = SCAN;
          end
        end else begin
          tmr_start = 1'b1;
        end
      end

      DONE: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          next_state = IDLE;
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs derived from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_state   <= IDLE;
      word_q      <= '0;
      acc         <= '0;
      err         <= 1'b0;
      idx         <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      res_rst_q   <= 1'b1;
      res_init_q  <= TRIT_ZERO;
    end else begin
      fsm_state   <= next_state;
      word_q      <= word_n;
      acc         <= acc_n;
      err         <= err_n;
      idx         <= idx_n;
      req_ready_q <= (next_state == IDLE);
      rsp_valid_q <= (next_state == DONE);
      res_rst_q   <= (next_state == LOAD);
      res_init_q  <= ((next_state == LOAD) || (next_state == SETTLE)) ? cur_trit : TRIT_ZERO;
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_word      = acc;
  assign bus.rsp_err       = err;
  assign res_rst           = res_rst_q;
  assign res_initial_state = res_init_q;
  assign state             = fsm_state;

endmodule

// File: tb/tb_trit_resolve_driver.sv
// Bench for trit_resolve_driver: resolver responder model, request driver,
// per-cycle comparison against a trit-level reference model, summary.
module tb_trit_resolve_driver;
  import trit_pkg::*;

  localparam int N  = 4;
  localparam int S  = 4;
  localparam int MW = 3;
  localparam int W  = 2 * N;

  typedef struct {
    int         delay;
    logic [1:0] val;
    bit         never;
  } res_cfg_t;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst_n;
  logic       res_rst;
  logic [1:0] res_initial_state;
  logic [1:0] res_resolved_state;
  drv_state_t state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  trit_resolve_driver_if #(.N_TRITS(N)) bus ();

  trit_resolve_driver #(
    .N_TRITS       (N),
    .SETTLE_CYCLES (S),
    .MAX_WAIT      (MW)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .bus                (bus),
    .res_rst            (res_rst),
    .res_initial_state  (res_initial_state),
    .res_resolved_state (res_resolved_state),
    .state              (state)
  );

  // ---------------- scoreboard state ----------------
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_err_q[$];
  int           exp_lat_q[$];
  int           exp_amb_q[$];
  res_cfg_t     res_q[$];

  bit           chk_en        = 0;
  bit           in_flight     = 0;
  bit           start_pending = 0;
  bit           seen_valid    = 0;
  int           n_cyc         = 0;
  int           cur_lat       = 0;
  int           cur_amb       = 0;
  int           pulses        = 0;
  logic [W-1:0] cur_w         = '0;
  logic         cur_err       = 1'b0;
  int           last_lat      = -1;
  int           last_pulses   = -1;
  logic [W-1:0] last_word     = '0;
  logic         last_err      = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- resolver responder model ----------------
  // Settles to cfg.val once cfg.delay cycles have elapsed since the load
  // (the load cycle counts as cycle 1); never settles if cfg.never.
  res_cfg_t rm_cfg;
  int       rm_cnt  = 0;
  bit       rm_live = 0;

  always @(posedge clk) begin
    if (rst_n && res_rst && (res_initial_state == 2'b10)) begin
      if (res_q.size() > 0) rm_cfg <= res_q.pop_front();
      else rm_cfg <= '{delay: 0, val: 2'b10, never: 1'b1};
      rm_cnt  <= 1;
      rm_live <= 1'b1;
    end else if (rm_cnt < 1000) begin
      rm_cnt <= rm_cnt + 1;
    end
  end

  assign res_resolved_state =
    (rm_live && !rm_cfg.never && (rm_cnt >= rm_cfg.delay)) ? rm_cfg.val : 2'b10;

  // ---------------- reference model ----------------
  // Trit-level prediction: resolved word, error flag, cycles from accept to
  // rsp_valid, and number of resolver loads.
  function automatic void predict(input logic [W-1:0] word, input res_cfg_t cfg[N],
                                  output logic [W-1:0] ow, output logic oerr,
                                  output int lat, output int amb);
    ow = '0; oerr = 1'b0; lat = 0; amb = 0;
    for (int i = 0; i < N; i++) begin
      logic [1:0] t;
      t = word[2*i +: 2];
      if (t != 2'b10) begin
        ow[2*i +: 2] = t;
        lat += 1;
      end else begin
        res_cfg_t c;
        int       waits;
        c = cfg[amb];
        amb++;
        waits = (c.delay > S) ? c.delay - S : 0;
        if (c.never || (c.val == 2'b10) || (waits > MW)) begin
          ow[2*i +: 2] = 2'b10;
          oerr = 1'b1;
          lat += S + 2 + MW;
        end else begin
          ow[2*i +: 2] = c.val;
          lat += S + 2 + waits;
        end
      end
    end
  endfunction

  function automatic res_cfg_t mk(input int d, input logic [1:0] v, input bit nv);
    res_cfg_t c;
    c.delay = d; c.val = v; c.never = nv;
    return c;
  endfunction

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n || !chk_en) begin
        in_flight     = 0;
        start_pending = 0;
      end else begin
        if (start_pending) begin
          start_pending = 0;
          in_flight     = 1;
          n_cyc         = 0;
          pulses        = 0;
          seen_valid    = 0;
          if (exp_q.size() > 0) begin
            cur_w   = exp_q.pop_front();
            cur_err = exp_err_q.pop_front();
            cur_lat = exp_lat_q.pop_front();
            cur_amb = exp_amb_q.pop_front();
          end
        end else if (in_flight) begin
          n_cyc++;
        end

        chk("req_ready", bus.req_ready, !in_flight);
        chk("rsp_valid", bus.rsp_valid, in_flight && (n_cyc >= cur_lat));

        if (!in_flight) begin
          chk("res_rst_idle", res_rst, 1'b0);
          chk("res_init_idle", res_initial_state, 2'b00);
        end else begin
          if (res_rst) begin
            pulses++;
            chk("res_init_load", res_initial_state, 2'b10);
          end
          chk("res_init_code", (res_initial_state == 2'b00) || (res_initial_state == 2'b10), 1'b1);
          if (bus.rsp_valid && !seen_valid) begin
            seen_valid = 1;
            last_lat   = n_cyc;
          end
          if (n_cyc >= cur_lat) begin
            chk("rsp_word", bus.rsp_word, cur_w);
            chk("rsp_err", bus.rsp_err, cur_err);
            chk("res_pulses", pulses, cur_amb);
            last_word   = bus.rsp_word;
            last_err    = bus.rsp_err;
            last_pulses = pulses;
            if (bus.rsp_ready) in_flight = 0;
          end
        end

        if (bus.req_valid && bus.req_ready) start_pending = 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] word, input res_cfg_t cfg[N],
                      input int bp, input bit wait_rsp);
    logic [W-1:0] ow;
    logic         oerr;
    int           lat;
    int           amb;
    int           t;
    predict(word, cfg, ow, oerr, lat, amb);
    exp_q.push_back(ow);
    exp_err_q.push_back(oerr);
    exp_lat_q.push_back(lat);
    exp_amb_q.push_back(amb);
    for (int i = 0; i < amb; i++) res_q.push_back(cfg[i]);

    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_word  = word;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.req_ready && (t < 50));
    chk("accept", bus.req_ready, 1'b1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_word  = W'($urandom);

    if (wait_rsp) begin
      t = 0;
      while (!bus.rsp_valid && (t < 200)) begin
        @(posedge clk); #1;
        t++;
      end
      chk("rsp_arrives", bus.rsp_valid, 1'b1);
      repeat (bp) begin
        @(posedge clk); #1;
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
    end
  endtask

  task automatic do_reset(input int hold);
    chk_en = 0;
    rst_n  = 1'b0;
    #1;
    chk("rst_req_ready", bus.req_ready, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_word", bus.rsp_word, '0);
    chk("rst_rsp_err", bus.rsp_err, 1'b0);
    chk("rst_res_rst", res_rst, 1'b1);
    chk("rst_res_init", res_initial_state, 2'b00);
    chk("rst_state", state, IDLE);
    exp_q.delete(); exp_err_q.delete(); exp_lat_q.delete(); exp_amb_q.delete();
    res_q.delete();
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (hold) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_req_ready", bus.req_ready, 1'b1);
    chk("rel_res_rst", res_rst, 1'b0);
    chk_en = 1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    res_cfg_t   cfg[N];
    logic [1:0] v;
    int         t;

    bus.req_valid = 1'b0;
    bus.req_word  = '0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b1;
    #3;
    do_reset(2);

    // 1: no ambiguous trits
    for (int i = 0; i < N; i++) cfg[i] = mk(4, 2'b01, 1'b0);
    send(8'b00_11_01_00, cfg, 0, 1);
    chk("t1_word", last_word, 8'b00_11_01_00);
    chk("t1_err", last_err, 1'b0);
    chk("t1_lat", last_lat, 4);
    chk("t1_pulses", last_pulses, 0);

    // 2: trit0 ambiguous, settles to +1 on the first sample
    cfg[0] = mk(4, 2'b01, 1'b0);
    send(8'b00_00_00_10, cfg, 0, 1);
    chk("t2_word", last_word, 8'b00_00_00_01);
    chk("t2_err", last_err, 1'b0);
    chk("t2_lat", last_lat, 9);
    chk("t2_pulses", last_pulses, 1);

    // 3: resolver never settles
    cfg[0] = mk(0, 2'b10, 1'b1);
    send(8'b10_00_00_00, cfg, 0, 1);
    chk("t3_word", last_word, 8'b10_00_00_00);
    chk("t3_err", last_err, 1'b1);
    chk("t3_lat", last_lat, 12);
    chk("t3_pulses", last_pulses, 1);

    // 4: response backpressure for 5 cycles (stability checked every cycle)
    cfg[0] = mk(2, 2'b11, 1'b0);
    send(8'b01_10_11_00, cfg, 5, 1);
    chk("t4_word", last_word, 8'b01_11_11_00);

    // 5: asynchronous reset while settling aborts the word
    cfg[0] = mk(4, 2'b01, 1'b0);
    send(8'b00_00_10_00, cfg, 0, 0);
    t = 0;
    while ((state != SETTLE) && (t < 20)) begin
      @(posedge clk); #1;
      t++;
    end
    chk("t5_in_settle", state, SETTLE);
    #2;
    do_reset(1);
    repeat (10) @(posedge clk);
    #1;
    chk("t5_no_rsp", bus.rsp_valid, 1'b0);
    cfg[0] = mk(5, 2'b11, 1'b0);
    send(8'b01_00_10_11, cfg, 1, 1);
    chk("t5_next_word", last_word, 8'b01_00_11_11);
    chk("t5_next_lat", last_lat, 10);

    // 6: every trit ambiguous
    cfg[0] = mk(4, 2'b11, 1'b0);
    cfg[1] = mk(4, 2'b01, 1'b0);
    cfg[2] = mk(4, 2'b00, 1'b0);
    cfg[3] = mk(4, 2'b11, 1'b0);
    send(8'b10_10_10_10, cfg, 0, 1);
    chk("t6_word", last_word, 8'b11_00_01_11);
    chk("t6_err", last_err, 1'b0);
    chk("t6_lat", last_lat, 24);
    chk("t6_pulses", last_pulses, 4);

    // Randomized words, resolver delays, values and backpressure
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 2))
          0:       v = 2'b00;
          1:       v = 2'b01;
          default: v = 2'b11;
        endcase
        cfg[i] = mk($urandom_range(1, 9), v, ($urandom_range(0, 7) == 0));
      end
      send(W'($urandom), cfg, $urandom_range(0, 3), 1);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
